// File: rtl/alsaqr_fpga_rst_seq.sv
// Board reset sequencer: debounces the reset button, qualifies clock lock, then
// releases the SoC reset followed by the HyperBus reset; any press or lock loss restarts it.
module alsaqr_fpga_rst_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int DEBOUNCE_CYCLES    = 1024,
  parameter int LOCK_WAIT_CYCLES   = 256,
  parameter int HOLD_CYCLES        = 64,
  parameter int HYPER_DELAY_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pad_reset_i,
  input  logic       locked_i,
  output logic       soc_rst_no,
  output logic       hyper_rst_no,
  output logic       rst_done_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    SOC_RUN   = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int MAX_HD = (HOLD_CYCLES > HYPER_DELAY_CYCLES) ? HOLD_CYCLES : HYPER_DELAY_CYCLES;
  localparam int MAX_C  = (LOCK_WAIT_CYCLES > MAX_HD) ? LOCK_WAIT_CYCLES : MAX_HD;
  localparam int CW     = $clog2(MAX_C + 1);
  localparam int DW     = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CW-1:0] LW_LAST = CW'(LOCK_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] HO_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] HD_LAST = CW'(HYPER_DELAY_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] pad_sync_q;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   btn_sync;
  logic                   lock_sync;
  logic                   btn_db_q;
  logic [DW-1:0]          db_cnt_q;
  logic                   ok;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          soc_d, hyper_d;

  // Synchronizers: the button idles "pressed" and lock idles "unlocked" so
  // nothing is released before real samples arrive.
  // NOTE: every clocked process uses non-blocking assignments so all flops
  // update from pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pad_sync_q  <= '1;
      lock_sync_q <= '0;
    end else begin
      pad_sync_q  <= {pad_sync_q[SYNC_STAGES-2:0], pad_reset_i};
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], locked_i};
    end
  end

  assign btn_sync  = pad_sync_q[SYNC_STAGES-1];
  assign lock_sync = lock_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_db_q <= 1'b1;
      db_cnt_q <= '0;
    end else if (btn_sync == btn_db_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_LAST) begin
      btn_db_q <= btn_sync;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + DW'(1);
    end
  end

  assign ok = !btn_db_q && lock_sync;

  // State register, shared phase counter and registered reset outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      soc_rst_no   <= 1'b0;
      hyper_rst_no <= 1'b0;
      rst_done_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      soc_rst_no   <= soc_d;
      hyper_rst_no <= hyper_d;
      rst_done_o   <= hyper_d;
    end
  end

  // NOTE: defaults at the top of every combinational process keep each
  // variable assigned on all paths, so no latches are inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!ok) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        WAIT_LOCK: if (cnt_q == LW_LAST) begin
                     state_d = HOLD;
                     cnt_d   = '0;
                   end else begin
                     cnt_d = cnt_q + CW'(1);
                   end
        HOLD:      if (cnt_q == HO_LAST) begin
                     state_d = SOC_RUN;
                     cnt_d   = '0;
                   end else begin
                     cnt_d = cnt_q + CW'(1);
                   end
        SOC_RUN:   if (cnt_q == HD_LAST) begin
                     state_d = RUN;
                     cnt_d   = '0;
                   end else begin
                     cnt_d = cnt_q + CW'(1);
                   end
        RUN:       cnt_d = '0;
        default:   state_d = WAIT_LOCK;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so SoC release
  // always precedes HyperBus release and aborts drop both on the same edge.
  always_comb begin
    soc_d   = (state_d == SOC_RUN) || (state_d == RUN);
    hyper_d = (state_d == RUN);
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_alsaqr_fpga_rst_seq.sv
// Self-checking bench for alsaqr_fpga_rst_seq: a run-length reference model
// checked every cycle, plus literal edge-timing checks for each scenario.
module tb_alsaqr_fpga_rst_seq;

  localparam int SYNC  = 2;
  localparam int DEB   = 8;
  localparam int LW    = 4;
  localparam int HO    = 4;
  localparam int HD    = 2;
  localparam int T_SOC = LW + HO;
  localparam int T_RUN = LW + HO + HD;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       pad   = 1'b0;
  logic       lock  = 1'b1;
  logic       soc_rst_n, hyper_rst_n, rst_done;
  logic [1:0] state;

  int n_pass  = 0;
  int n_total = 0;

  alsaqr_fpga_rst_seq #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .LOCK_WAIT_CYCLES(LW),
    .HOLD_CYCLES(HO), .HYPER_DELAY_CYCLES(HD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .pad_reset_i(pad), .locked_i(lock),
    .soc_rst_no(soc_rst_n), .hyper_rst_no(hyper_rst_n),
    .rst_done_o(rst_done), .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: delay lines for the synchronizers, a run length of
  // differing button samples, and a run length of consecutive qualified edges.
  // The reset outputs and state are pure functions of that qualified run length.
  logic [SYNC-1:0] m_pad_h, m_lock_h;
  logic            m_btn_db;
  int              m_db_run, m_ok_run, m_edge;
  wire             m_ok = !m_btn_db && m_lock_h[SYNC-1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pad_h  <= '1;
      m_lock_h <= '0;
      m_btn_db <= 1'b1;
      m_db_run <= 0;
      m_ok_run <= 0;
      m_edge   <= 0;
    end else begin
      m_edge   <= m_edge + 1;
      m_ok_run <= !m_ok ? 0 : (m_ok_run < T_RUN ? m_ok_run + 1 : m_ok_run);
      if (m_pad_h[SYNC-1] == m_btn_db) m_db_run <= 0;
      else if (m_db_run + 1 == DEB) begin
        m_btn_db <= m_pad_h[SYNC-1];
        m_db_run <= 0;
      end else m_db_run <= m_db_run + 1;
      m_pad_h  <= {m_pad_h[SYNC-2:0], pad};
      m_lock_h <= {m_lock_h[SYNC-2:0], lock};
    end
  end

  function automatic int exp_state(input int r);
    if (r < LW)    return 0;
    if (r < T_SOC) return 1;
    if (r < T_RUN) return 2;
    return 3;
  endfunction

  always @(negedge clk) begin
    check("soc_rst_no",   soc_rst_n,   int'(m_ok_run >= T_SOC));
    check("hyper_rst_no", hyper_rst_n, int'(m_ok_run >= T_RUN));
    check("rst_done_o",   rst_done,    int'(m_ok_run >= T_RUN));
    check("state_o",      state,       exp_state(m_ok_run));
    check("order_hyper_implies_soc", int'(hyper_rst_n && !soc_rst_n), 0);
  end

  task automatic goto_edge(input int e);
    int k = 0;
    while (m_edge < e && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (m_edge != e) check("edge_reached", m_edge, e);
  endtask

  task automatic wait_state(input int s);
    int k = 0;
    while (int'(state) != s && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("wait_state", state, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_soc",   soc_rst_n,   0);
    check("rst_hyper", hyper_rst_n, 0);
    check("rst_done",  rst_done,    0);
    check("rst_state", state,       0);

    // Nominal release: the first posedge after this is edge 1.
    rst_n = 1'b1;
    goto_edge(13); check("nom_state_e13", state, 0);
    goto_edge(14); check("nom_state_e14", state, 1);
    goto_edge(17); check("nom_soc_e17", soc_rst_n, 0);
    goto_edge(18); check("nom_soc_e18", soc_rst_n, 1);
                   check("nom_state_e18", state, 2);
    goto_edge(19); check("nom_hyper_e19", hyper_rst_n, 0);
    goto_edge(20); check("nom_hyper_e20", hyper_rst_n, 1);
                   check("nom_done_e20", rst_done, 1);
                   check("nom_state_e20", state, 3);

    // Button glitch of 7 sampled cycles: must be swallowed.
    repeat (2) @(negedge clk);
    pad = 1'b1;
    repeat (7) @(negedge clk);
    pad = 1'b0;
    repeat (15) @(negedge clk);
    check("glitch_state", state, 3);
    check("glitch_soc", soc_rst_n, 1);
    check("glitch_hyper", hyper_rst_n, 1);

    // Real press: resets fall on the 11th edge counting the sampling edge.
    pad = 1'b1;
    e0 = m_edge + 1;
    goto_edge(e0 + 9);  check("press_soc_still_high", soc_rst_n, 1);
    goto_edge(e0 + 10); check("press_soc", soc_rst_n, 0);
                        check("press_hyper", hyper_rst_n, 0);
                        check("press_done", rst_done, 0);
                        check("press_state", state, 0);
    pad = 1'b0;

    // Lock loss while in HOLD.
    wait_state(1);
    lock = 1'b0;
    e0 = m_edge + 1;
    goto_edge(e0 + 1); check("hold_loss_state_e2", state, 1);
    goto_edge(e0 + 2); check("hold_loss_state_e3", state, 0);
                       check("hold_loss_soc", soc_rst_n, 0);
    repeat (3) @(negedge clk);
    lock = 1'b1;
    e0 = m_edge + 1;
    goto_edge(e0 + 8); check("relock_soc_e9", soc_rst_n, 0);
    goto_edge(e0 + 9); check("relock_soc_e10", soc_rst_n, 1);

    // Single-cycle lock drop while qualifying in WAIT_LOCK restarts the count.
    wait_state(3);
    lock = 1'b0;
    e0 = m_edge + 1;
    @(negedge clk);
    lock = 1'b1;
    goto_edge(e0 + 2); check("blip_abort_state", state, 0);
    lock = 1'b0;
    @(negedge clk);
    lock = 1'b1;
    goto_edge(e0 + 8);  check("blip_state_still_wait", state, 0);
    goto_edge(e0 + 9);  check("blip_state_hold", state, 1);
    goto_edge(e0 + 12); check("blip_soc_low", soc_rst_n, 0);
    goto_edge(e0 + 13); check("blip_soc_high", soc_rst_n, 1);

    // Asynchronous reset mid-cycle while in SOC_RUN.
    wait_state(3);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_state(2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_soc", soc_rst_n, 0);
    check("async_state", state, 0);
    check("async_hyper", hyper_rst_n, 0);
    @(negedge clk);
    rst_n = 1'b1;
    goto_edge(17); check("restart_soc_e17", soc_rst_n, 0);
    goto_edge(18); check("restart_soc_e18", soc_rst_n, 1);
    goto_edge(20); check("restart_hyper_e20", hyper_rst_n, 1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
